// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard and issue control for the no-forwarding MIPS pipeline
module hazard_scoreboard #(
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [31:0]      busy_mask,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [2:0] LAT = 3'(WB_LAT);

  logic [2:0] cnt [1:31];
  logic       hazard;
  logic       set_en;

  // Single issue with fixed latency means at most one counter is at 1, so OR-ing indices is exact.
  always_comb begin
    busy_mask = '0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    for (int n = 1; n < 32; n++) begin
      busy_mask[n] = (cnt[n] != 3'd0);
      if (cnt[n] == 3'd1) begin
        wb_valid = 1'b1;
        wb_reg   = wb_reg | 5'(n);
      end
    end
  end

  assign hazard = ((id_rs != 5'd0) && busy_mask[id_rs]) ||
                  (id_uses_rt && (id_rt != 5'd0) && busy_mask[id_rt]);
  assign stall  = id_valid && hazard && !flush;
  assign issue  = id_valid && !hazard && !flush;
  assign set_en = issue && id_regwrite && (id_rd != 5'd0);

  // A new write to a busy register reloads its counter; the older completion is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n < 32; n++) cnt[n] <= 3'd0;
      stall_count <= '0;
    end else begin
      for (int n = 1; n < 32; n++) begin
        if (set_en && (id_rd == 5'(n))) cnt[n] <= LAT;
        else if (cnt[n] != 3'd0)        cnt[n] <= cnt[n] - 3'd1;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue controller for the two-register-stage MIPS pipeline, which has no forwarding.
- Tracks every architectural register with a pending write from an instruction already issued past the decode register.
- Stalls decode on read-after-write hazards and tells the pipeline when to issue an instruction and when to insert a bubble.
- Sits between the decode register output, the control unit and the PC/decode-register enables; also reports write-back completion and a stall performance counter.

Parameters:
- WB_LAT, 2: cycles from issue edge to register-file write edge; legal range 1..7.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode register holds a real instruction
- id_rs  in  5  source register 1 (instr[25:21])
- id_rt  in  5  source register 2 (instr[20:16])
- id_uses_rt  in  1  instruction reads rt as a source
- id_rd  in  5  destination register
- id_regwrite  in  1  instruction writes id_rd
- flush  in  1  kill the instruction currently in decode
- stall  out  1  hold PC and decode register this cycle
- issue  out  1  advance decode instruction into the execute register; 0 = bubble
- busy_mask  out  32  bit n = register n has a pending write
- wb_valid  out  1  a tracked write completes at the coming edge
- wb_reg  out  5  register being written when wb_valid=1, else 0
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: one down-counter per register, cnt[1..31], 3 bits each; cnt[0] is constant 0.
- busy[n] = (cnt[n] != 0). busy_mask = busy; bit 0 is always 0.
- hazard = (id_rs!=0 & busy[id_rs]) | (id_uses_rt & id_rt!=0 & busy[id_rt]). Combinational from registered state only.
- stall = id_valid & hazard & ~flush.
- issue = id_valid & ~hazard & ~flush.
- All outputs are combinational from inputs and registered state; no output-path latency.
- Per clock edge:
  - every nonzero cnt decrements by 1;
  - then, if issue & id_regwrite & id_rd!=0, cnt[id_rd] <= WB_LAT. Set wins over decrement on the same register.
- WAW case: an issuing write to an already-busy register reloads its counter to WB_LAT. Only the latest write is reported; the earlier completion is not signalled.
- wb_valid = 1 when some cnt[n]==1; wb_reg = that n. At most one counter can equal 1 in a cycle (single issue, fixed latency), so no priority logic is needed. When wb_valid=0, wb_reg=0.
- A register is still busy in the cycle its cnt==1. A dependent instruction issues the cycle after the write edge, giving WB_LAT stall cycles for back-to-back dependence.
- stall_count increments on every edge where stall=1 and saturates at all-ones.
- flush has priority over stall: stall=0, issue=0, no scoreboard set. In-flight counters keep decrementing.
- id_valid=0 gives stall=0 and issue=0. Counters keep decrementing.
- Reset (rst_n=0, asynchronous, valid mid-operation): all cnt=0 and stall_count=0 immediately. Therefore busy_mask=0, wb_valid=0, wb_reg=0, and stall/issue follow the combinational equations with no hazard. Release is synchronous to the next clk edge.

Test Plan:
- WB_LAT=2. Issue rd=3 regwrite at edge t0; next instr rs=3 valid -> stall=1 in cycles t1 and t2; wb_valid=1 with wb_reg=3 in t2; issue=1 in t3; stall_count=2.
- Issue rd=5, then rs=6, rt=7, uses_rt=1 -> no stall; busy_mask=0x20 for 2 cycles, then 0.
- Issue rd=0 regwrite, then rs=0 -> busy_mask stays 0, no stall, wb_valid never asserted.
- rd=9 busy; next instr rt=9 with uses_rt=0 -> issue=1, stall=0. Same instr with uses_rt=1 -> stall=1.
- During a stall on r4, assert flush for one cycle -> stall=0, issue=0, stall_count unchanged that cycle; r4 still completes on schedule (wb_reg=4).
- rd=10 and rd=11 in flight; drop rst_n between edges -> busy_mask=0 and stall_count=0 before the next edge. After release, a rs=10 instruction issues with no stall.
- CNT_W=4; force 20 consecutive stall cycles -> stall_count holds at 15.
